// File: rtl/alu_wb_pkg.sv
// Shared types, default widths and the age-ordered priority search used
// by the ALU write-back buffer.
package alu_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_DEPTH  = 16;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] result;
  } wb_entry_t;

  // Bit i marks a match on the i-th oldest entry; the highest set bit is the youngest.
  function automatic logic [3:0] youngest_match(input logic [MAX_DEPTH-1:0] match_by_age);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (match_by_age[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic synchronous FIFO with occupancy count and an age-ordered flat view
// of the storage (slot 0 = head) for associative searches.
module alu_wb_fifo
  import alu_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W_DEF + ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH*WIDTH-1:0]   age_view
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] age_idx;

  // Callers guarantee push only when not full and pop only when not empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

  always_comb begin
    age_view = '0;
    age_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx = head + PTR_W'(i);
      age_view[i*WIDTH +: WIDTH] = mem[age_idx];
    end
  end

endmodule

// File: rtl/alu_wb_buffer.sv
// In-order write-back buffer between the ALU result path and the register file,
// with x0 discard, two forwarding lookup ports and a sticky last zero flag.
module alu_wb_buffer
  import alu_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_rd,
  input  logic [DATA_W-1:0]      in_result,
  input  logic                   in_zero,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic                   rf_stall,
  input  logic [ADDR_W-1:0]      fwd_rs1,
  input  logic [ADDR_W-1:0]      fwd_rs2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DATA_W-1:0]      fwd_data1,
  output logic [DATA_W-1:0]      fwd_data2,
  output logic                   last_zero,
  output logic [$clog2(DEPTH):0] count
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ENT_W-1:0]       head_data;
  logic [DEPTH*ENT_W-1:0] age_view;
  logic [ADDR_W-1:0]      head_rd;
  logic [DATA_W-1:0]      head_result;
  logic                   empty;
  logic                   push;
  logic                   pop;

  alu_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .wdata     ({in_rd, in_result}),
    .head_data (head_data),
    .count     (count),
    .age_view  (age_view)
  );

  assign empty       = (count == '0);
  assign head_rd     = head_data[ENT_W-1 -: ADDR_W];
  assign head_result = head_data[DATA_W-1:0];

  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  // x0 entries never reach the register file, so they drain even under stall.
  assign pop      = !empty && (!rf_stall || (head_rd == '0));

  assign rf_we    = !empty && (head_rd != '0);
  assign rf_waddr = empty ? '0 : head_rd;
  assign rf_wdata = empty ? '0 : head_result;

  logic [MAX_DEPTH-1:0] match1;
  logic [MAX_DEPTH-1:0] match2;
  logic [3:0]           young1;
  logic [3:0]           young2;
  logic [ADDR_W-1:0]    ent_rd;
  logic                 live;

  always_comb begin
    match1 = '0;
    match2 = '0;
    ent_rd = '0;
    live   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd    = age_view[i*ENT_W + DATA_W +: ADDR_W];
      live      = (CNT_W'(i) < count);
      match1[i] = live && (fwd_rs1 != '0) && (ent_rd == fwd_rs1);
      match2[i] = live && (fwd_rs2 != '0) && (ent_rd == fwd_rs2);
    end
    young1    = youngest_match(match1);
    young2    = youngest_match(match2);
    fwd_hit1  = |match1;
    fwd_hit2  = |match2;
    fwd_data1 = fwd_hit1 ? age_view[int'(young1)*ENT_W +: DATA_W] : '0;
    fwd_data2 = fwd_hit2 ? age_view[int'(young2)*ENT_W +: DATA_W] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    last_zero <= 1'b0;
    else if (push) last_zero <= in_zero;
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: a queue-based reference model predicts
// occupancy, head, forwarding and the ordered stream of register-file writes.
module tb_alu_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_zero;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_stall;
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        last_zero;
  logic [2:0]  count;

  always #5 clk = ~clk;

  alu_wb_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_result (in_result),
    .in_zero   (in_zero),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_stall  (rf_stall),
    .fwd_rs1   (fwd_rs1),
    .fwd_rs2   (fwd_rs2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .last_zero (last_zero),
    .count     (count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
  } ent_t;

  ent_t mq[$];
  ent_t exp_wr[$];
  logic m_last;
  bit   chk_en;
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_fwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 0) begin
      foreach (mq[i]) begin
        if (mq[i].rd == rs) begin
          hit = 1'b1;
          d   = mq[i].res;
        end
      end
    end
  endfunction

  // Advance one edge and apply the same edge to the reference model.
  task automatic step();
    int sz;
    bit do_pop, do_push;
    ent_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      exp_wr.delete();
      m_last = 1'b0;
    end else begin
      sz      = mq.size();
      do_pop  = (sz != 0) && (!rf_stall || mq[0].rd == 0);
      do_push = in_valid && (sz < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.rd  = in_rd;
        e.res = in_result;
        mq.push_back(e);
        m_last = in_zero;
        if (in_rd != 0) exp_wr.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] r,
                       input logic z, input logic st);
    in_valid  = v;
    in_rd     = rd;
    in_result = r;
    in_zero   = z;
    rf_stall  = st;
  endtask

  // State checker: compares all visible outputs with the model between edges.
  initial begin
    logic        eh1, eh2;
    logic [31:0] ed1, ed2;
    int          sz;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        sz = mq.size();
        model_fwd(fwd_rs1, eh1, ed1);
        model_fwd(fwd_rs2, eh2, ed2);
        check("count",     32'(count),     32'(sz));
        check("in_ready",  32'(in_ready),  32'(sz < DEPTH));
        check("rf_we",     32'(rf_we),     32'((sz != 0) && (mq[0].rd != 0)));
        check("rf_waddr",  32'(rf_waddr),  (sz != 0) ? 32'(mq[0].rd) : 32'd0);
        check("rf_wdata",  rf_wdata,       (sz != 0) ? mq[0].res : 32'd0);
        check("fwd_hit1",  32'(fwd_hit1),  32'(eh1));
        check("fwd_data1", fwd_data1,      ed1);
        check("fwd_hit2",  32'(fwd_hit2),  32'(eh2));
        check("fwd_data2", fwd_data2,      ed2);
        check("last_zero", 32'(last_zero), 32'(m_last));
      end
    end
  end

  // Write monitor: every completed register-file write must match the next expected one.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (chk_en && rst_n && rf_we && !rf_stall) begin
        if (exp_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rf_write: unexpected write x%0d=0x%0h, none expected", rf_waddr, rf_wdata);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(rf_waddr), 32'(e.rd));
          check("wr_data", rf_wdata, e.res);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    m_last  = 1'b0;
    rst_n   = 1'b0;
    fwd_rs1 = 5'd5;
    fwd_rs2 = 5'd0;
    drive(0, 0, 0, 0, 0);
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset then idle
    check("rst_count",     32'(count),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_rf_we",     32'(rf_we),     32'd0);
    check("rst_last_zero", 32'(last_zero), 32'd0);
    check("rst_fwd_hit1",  32'(fwd_hit1),  32'd0);

    // Single write
    drive(1, 5'd5, 32'h36, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check("single_we",    32'(rf_we),    32'd1);
    check("single_waddr", 32'(rf_waddr), 32'd5);
    check("single_wdata", rf_wdata,      32'h36);
    step();
    check("single_drain", 32'(count), 32'd0);

    // Fill under stall, reject a fifth, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 32'h100 + 32'(i), 0, 1);
      step();
    end
    check("fill_count", 32'(count),    32'd4);
    check("fill_ready", 32'(in_ready), 32'd0);
    drive(1, 5'd9, 32'h999, 0, 1);
    step();
    check("fill_reject", 32'(count), 32'd4);
    drive(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      check("drain_we",    32'(rf_we),    32'd1);
      check("drain_order", 32'(rf_waddr), 32'(i));
      step();
    end
    check("drain_empty", 32'(count), 32'd0);

    // Full with simultaneous pop
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i + 10), 32'h200 + 32'(i), 0, 1);
      step();
    end
    drive(1, 5'd20, 32'h2020, 0, 0);
    check("full_ready", 32'(in_ready), 32'd0);
    step();
    check("full_pop_count", 32'(count), 32'd3);
    step();
    check("push_pop_count", 32'(count), 32'd3);
    drive(0, 0, 0, 0, 0);
    repeat (4) step();
    check("full_drain", 32'(count), 32'd0);

    // x0 entry discarded under stall, zero flag captured
    drive(1, 5'd0, 32'd0, 1, 1);
    step();
    drive(0, 0, 0, 0, 1);
    check("x0_we",        32'(rf_we),     32'd0);
    check("x0_count",     32'(count),     32'd1);
    check("x0_last_zero", 32'(last_zero), 32'd1);
    step();
    check("x0_popped", 32'(count), 32'd0);

    // Forwarding priority and reset clearing
    drive(1, 5'd7, 32'hAAAA_0001, 0, 1);
    step();
    drive(1, 5'd7, 32'h5555_0002, 0, 1);
    step();
    drive(0, 0, 0, 0, 1);
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd0;
    #1;
    check("fwd_prio_hit1",  32'(fwd_hit1), 32'd1);
    check("fwd_prio_data1", fwd_data1,     32'h5555_0002);
    check("fwd_x0_hit2",    32'(fwd_hit2), 32'd0);
    rst_n = 1'b0;
    step();
    check("fwd_rst_hit1",  32'(fwd_hit1), 32'd0);
    check("fwd_rst_count", 32'(count),    32'd0);
    rst_n = 1'b1;

    // Randomized traffic with occasional resets
    repeat (3000) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive(($urandom % 10) < 6,
            ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
            $urandom, 1'($urandom), ($urandom % 10) < 3);
      fwd_rs1 = 5'($urandom_range(0, 7));
      fwd_rs2 = 5'($urandom_range(0, 7));
      step();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (8) step();
    check("final_count",  32'(count),         32'd0);
    check("final_wr_out", 32'(exp_wr.size()), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
